mux2to1_32bits: RTL and testbench
=================================

MUX2TO1_32BITS -- requirements
Module: mux2to1_32bits

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the data width of A, B, Out and Out_q.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all sequential logic updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port A, input, WIDTH bits: data input selected when Sel=0.
REQ-005 The block SHALL have port B, input, WIDTH bits: data input selected when Sel=1.
REQ-006 The block SHALL have port Sel, input, 1 bit: select line.
REQ-007 The block SHALL have port Out, output, WIDTH bits: combinational mux result.
REQ-008 The block SHALL have port Out_q, output, WIDTH bits: registered copy of Out, present only per REQ-020.
REQ-009 The block SHALL have port sel_invalid, output, 1 bit: combinational flag, high when Sel is X or Z.

Function
REQ-010 Out SHALL equal A when Sel=0 and B when Sel=1, purely combinationally, with zero clock latency and independent of clk and rst_n.
REQ-011 Out SHALL settle within the same simulation time step as any change on A, B or Sel.
REQ-012 When Sel is X or Z, Out SHALL be all-X on every bit, and SHALL NOT silently choose A or B.
REQ-013 When Sel is X or Z and A==B, Out SHALL still be all-X, with no merging of equal inputs.
REQ-014 sel_invalid SHALL be 1 when Sel is X or Z, and 0 otherwise.
REQ-015 sel_invalid SHALL be a simulation-only construct; in synthesis it SHALL be tied to 0.
REQ-016 When A==B, Out SHALL equal that common value for Sel=0 and for Sel=1.
REQ-017 Out SHALL respond to Sel toggles at any rate, with no glitch-filtering and no hold of prior state.

Reset
REQ-018 While rst_n=0 at a rising clk edge, Out_q SHALL load 0.
REQ-019 Reset SHALL have no effect on Out or sel_invalid, which remain combinational during and after reset.

Configuration
REQ-020 The macro MUX2TO1_REG_OUT_EN SHALL control whether the output register is compiled in.
- Defined: Out_q SHALL load Out on every rising clk edge while rst_n=1, giving one cycle of latency.
- Not defined: the register SHALL be removed and Out_q SHALL be tied to constant 0.
- In both cases, Out behaviour SHALL be identical.

Verification
REQ-021 The bench SHALL cover a basic select check:
- Stimulus: A=DEADBEEF, B=CAFEBABE, Sel=0, then Sel=1.
- Required response: Out=DEADBEEF, then Out=CAFEBABE, each within 10 ns.
REQ-022 The bench SHALL cover corner values:
- Stimulus: A=B=00000000 and A=B=FFFFFFFF, each with Sel=0 and Sel=1.
- Required response: Out=00000000 and Out=FFFFFFFF respectively, for both Sel values.
REQ-023 The bench SHALL cover rapid toggling:
- Stimulus: A=AAAAAAAA, B=55555555, Sel toggled 0/1/0 at 5 ns intervals.
- Required response: Out=AAAAAAAA / 55555555 / AAAAAAAA.
REQ-024 The bench SHALL cover an invalid select:
- Stimulus: Sel=X with A=AAAAAAAA, B=55555555.
- Required response: Out all-X and sel_invalid=1.
REQ-025 The bench SHALL cover reset and the registered output, with MUX2TO1_REG_OUT_EN defined:
- Stimulus: rst_n=0 for 1 edge, then release with A=12345678, Sel=0.
- Required response: Out_q=0 during reset; Out_q=12345678 on the first edge after release.
- Required response: Out=12345678 throughout, including during reset.
REQ-026 The bench SHALL cover the macro undefined:
- Stimulus: repeat REQ-025 without MUX2TO1_REG_OUT_EN.
- Required response: Out_q=0 at all times; Out identical to REQ-025.

Source files
------------

// File: rtl/mux2to1_32bits.sv
// 2:1 WIDTH-bit mux with X-propagating select and an optional output register.
// Define MUX2TO1_REG_OUT_EN to compile in the Out_q register; otherwise Out_q is 0.
module mux2to1_32bits #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sel,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] Out_q,
  output logic             sel_invalid
);

  // case matches exactly, so an X/Z select never merges equal inputs
  always_comb begin
    Out = 'x;
    case (Sel)
      1'b0:    Out = A;
      1'b1:    Out = B;
      default: Out = 'x;
    endcase
  end

`ifdef SYNTHESIS
  assign sel_invalid = 1'b0;
`else
  assign sel_invalid = $isunknown(Sel);
`endif

`ifdef MUX2TO1_REG_OUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) Out_q <= '0;
    else        Out_q <= Out;
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst_n};
  assign Out_q = '0;
`endif

endmodule

// File: tb/tb_mux2to1_32bits.sv
// Randomized self-checking bench for mux2to1_32bits.
// Registered-output expectations follow MUX2TO1_REG_OUT_EN.
module tb_mux2to1_32bits;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic        sel;
  logic [31:0] out, out_q;
  logic        sel_invalid;

  int n_checks = 0;
  int n_fails  = 0;

  mux2to1_32bits #(.WIDTH(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .A(a),
    .B(b),
    .Sel(sel),
    .Out(out),
    .Out_q(out_q),
    .sel_invalid(sel_invalid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_out(
    input logic [31:0] ra, input logic [31:0] rb, input logic rs
  );
    if ($isunknown(rs)) return 'x;
    return rs ? rb : ra;
  endfunction

  function automatic logic [31:0] ref_reg(
    input logic rrst, input logic [31:0] rval
  );
`ifdef MUX2TO1_REG_OUT_EN
    return rrst ? rval : 32'h0;
`else
    return 32'h0;
`endif
  endfunction

  task automatic test_reset();
    logic [31:0] exp_q;
    @(negedge clk);
    rst_n = 1'b0;
    a = 32'h12345678;
    b = $urandom;
    sel = 1'b0;
    #1;
    n_checks++;
    if (out !== 32'h12345678) begin
      n_fails++;
      $display("FAIL rst_out_pre got=%h exp=12345678", out);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_q !== 32'h0) begin
      n_fails++;
      $display("FAIL rst_out_q got=%h exp=00000000", out_q);
    end
    n_checks++;
    if (out !== 32'h12345678) begin
      n_fails++;
      $display("FAIL rst_out_during got=%h exp=12345678", out);
    end
    n_checks++;
    if (sel_invalid !== 1'b0) begin
      n_fails++;
      $display("FAIL rst_sel_invalid got=%b exp=0", sel_invalid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q = ref_reg(1'b1, 32'h12345678);
    n_checks++;
    if (out_q !== exp_q) begin
      n_fails++;
      $display("FAIL rel_out_q got=%h exp=%h", out_q, exp_q);
    end
    n_checks++;
    if (out !== 32'h12345678) begin
      n_fails++;
      $display("FAIL rel_out got=%h exp=12345678", out);
    end
  endtask

  task automatic test_basic_select();
    @(negedge clk);
    a = 32'hDEADBEEF;
    b = 32'hCAFEBABE;
    sel = 1'b0;
    #1;
    n_checks++;
    if (out !== 32'hDEADBEEF) begin
      n_fails++;
      $display("FAIL basic_sel0 got=%h exp=deadbeef", out);
    end
    sel = 1'b1;
    #1;
    n_checks++;
    if (out !== 32'hCAFEBABE) begin
      n_fails++;
      $display("FAIL basic_sel1 got=%h exp=cafebabe", out);
    end
  endtask

  task automatic test_corner();
    logic [31:0] v;
    for (int i = 0; i < 2; i++) begin
      v = (i == 0) ? 32'h0 : 32'hFFFF_FFFF;
      for (int s = 0; s < 2; s++) begin
        a = v;
        b = v;
        sel = s[0];
        #1;
        n_checks++;
        if (out !== v) begin
          n_fails++;
          $display("FAIL corner v=%h sel=%0d got=%h", v, s, out);
        end
      end
    end
  endtask

  task automatic test_toggle();
    logic [31:0] exp;
    a = 32'hAAAA_AAAA;
    b = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      sel = (i == 1);
      exp = (i == 1) ? 32'h5555_5555 : 32'hAAAA_AAAA;
      #1;
      n_checks++;
      if (out !== exp) begin
        n_fails++;
        $display("FAIL toggle step=%0d got=%h exp=%h", i, out, exp);
      end
      #4;
    end
  endtask

  task automatic test_invalid_select();
    logic [31:0] exp;
    logic        exp_inv;
    for (int i = 0; i < 2; i++) begin
      a = 32'hAAAA_AAAA;
      b = (i == 0) ? 32'h5555_5555 : 32'hAAAA_AAAA;
      sel = 1'bx;
      #1;
      exp = ref_out(a, b, sel);
      exp_inv = $isunknown(sel);
      n_checks++;
      if (out !== exp) begin
        n_fails++;
        $display("FAIL invalid_out case=%0d got=%h exp=%h", i, out, exp);
      end
      n_checks++;
      if (sel_invalid !== exp_inv) begin
        n_fails++;
        $display("FAIL invalid_flag case=%0d got=%b exp=%b",
                 i, sel_invalid, exp_inv);
      end
    end
    sel = 1'b0;
    #1;
  endtask

  task automatic test_random();
    logic [31:0] exp, exp_q;
    logic        rst_now;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      sel = 1'($urandom_range(0, 1));
      rst_now = ($urandom_range(0, 9) != 0);
      rst_n = rst_now;
      #1;
      exp = ref_out(a, b, sel);
      n_checks++;
      if (out !== exp) begin
        n_fails++;
        $display("FAIL rand_out i=%0d got=%h exp=%h", i, out, exp);
      end
      n_checks++;
      if (sel_invalid !== 1'b0) begin
        n_fails++;
        $display("FAIL rand_flag i=%0d got=%b exp=0", i, sel_invalid);
      end
      @(posedge clk); #1;
      exp_q = ref_reg(rst_now, exp);
      n_checks++;
      if (out_q !== exp_q) begin
        n_fails++;
        $display("FAIL rand_out_q i=%0d got=%h exp=%h", i, out_q, exp_q);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    a = '0;
    b = '0;
    sel = 1'b0;
    test_reset();
    test_basic_select();
    test_corner();
    test_toggle();
    test_invalid_select();
    test_random();
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
